// File: rtl/seg7_scan_decoder_if.sv
// Pin-level seven-segment scan bus as seen on the display pins (all lines active-low).
// The display driver owns the master side; the loop-back decoder listens on the slave side.
interface seg7_scan_decoder_if;
    logic [6:0] seg_in;
    logic [3:0] an_in;

    modport master (output seg_in, output an_in);
    modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Loop-back monitor for a multiplexed 4-digit seven-segment scan: syncs, debounces, decodes, reassembles frames.
// Optional SEG7_SCAN_ERRCNT_EN adds a saturating count of decode_err pulses on decode_err_count.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic               clk,
    input  logic               reset_n,
    seg7_scan_decoder_if.slave bus,
    output logic [13:0]        value_out,
    output logic               value_valid,
    output logic               error_shown,
    output logic               decode_err,
    output logic               stale,
    output logic [7:0]         decode_err_count
);

    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      STAB_PRE = 8'(STABLE_CYCLES - 2);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_END   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [3:0]      C_E      = 4'hA;
    localparam logic [3:0]      C_R      = 4'hB;
    localparam logic [3:0]      C_BLANK  = 4'hF;

    // Bit 4 flags an illegal pattern; bits 3:0 hold the slot code.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h10;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            7'b0000110: r = {1'b0, C_E};
            7'b0101111: r = {1'b0, C_R};
            7'b1111111: r = {1'b0, C_BLANK};
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    function automatic logic all_numeric(input logic [3:0][3:0] s);
        return (s[3] <= 4'd9) && (s[2] <= 4'd9) && (s[1] <= 4'd9) && (s[0] <= 4'd9);
    endfunction

    function automatic logic [13:0] frame_value(input logic [3:0][3:0] s);
        int v;
        v = int'(s[3]) * 1000 + int'(s[2]) * 100 + int'(s[1]) * 10 + int'(s[0]);
        return 14'(v);
    endfunction

    logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic [3:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
    logic [7:0]       stab_cnt_q, stab_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  slot_q, slot_d;
    logic [13:0]      value_q, value_d;
    logic             value_valid_q, value_valid_d;
    logic             error_shown_q, error_shown_d;
    logic             decode_err_q, decode_err_d;
    logic             stale_q, stale_d;

    logic             changed, accept, onehot;
    logic [1:0]       k_idx;
    logic [4:0]       dec;
    logic [3:0][3:0]  slot_new;
    logic [3:0]       mask_new;

    always_comb begin
        seg_s1_d      = bus.seg_in;
        an_s1_d       = bus.an_in;
        seg_s2_d      = seg_s1_q;
        an_s2_d       = an_s1_q;
        seg_prev_d    = seg_s2_q;
        an_prev_d     = an_s2_q;
        stab_cnt_d    = stab_cnt_q;
        to_cnt_d      = to_cnt_q;
        mask_d        = mask_q;
        slot_d        = slot_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        error_shown_d = error_shown_q;
        decode_err_d  = 1'b0;
        stale_d       = stale_q;
        onehot        = 1'b1;
        k_idx         = 2'd0;
        dec           = seg_decode(seg_s2_q);
        slot_new      = slot_q;
        mask_new      = mask_q;

        // Stability filter on the synced copy; accept on the cycle the count reaches STABLE_CYCLES-1.
        changed = {seg_s2_q, an_s2_q} != {seg_prev_q, an_prev_q};
        accept  = !changed && (stab_cnt_q == STAB_PRE);
        if (changed)
            stab_cnt_d = 8'd0;
        else if (stab_cnt_q != 8'hFF)
            stab_cnt_d = stab_cnt_q + 8'd1;

        if (to_cnt_q != TO_END)
            to_cnt_d = to_cnt_q + TO_ONE;
        if (to_cnt_q == TO_LAST) begin
            stale_d = 1'b1;
            mask_d  = 4'b0000;
        end

        case (an_s2_q)
            4'b0111: k_idx = 2'd3;
            4'b1011: k_idx = 2'd2;
            4'b1101: k_idx = 2'd1;
            4'b1110: k_idx = 2'd0;
            default: onehot = 1'b0;
        endcase

        // A non-blank acceptance overrides a coincident timeout.
        if (accept && (an_s2_q != 4'b1111)) begin
            to_cnt_d = '0;
            stale_d  = stale_q;
            mask_d   = mask_q;
            if (!onehot || dec[4]) begin
                decode_err_d = 1'b1;
                mask_d       = 4'b0000;
            end else begin
                slot_new[k_idx] = dec[3:0];
                mask_new        = mask_q | (4'b0001 << k_idx);
                slot_d          = slot_new;
                mask_d          = mask_new;
                if (mask_new == 4'b1111) begin
                    mask_d = 4'b0000;
                    if (all_numeric(slot_new)) begin
                        value_d       = frame_value(slot_new);
                        value_valid_d = 1'b1;
                        error_shown_d = 1'b0;
                        stale_d       = 1'b0;
                    end else if (slot_new == {C_E, C_R, C_R, C_BLANK}) begin
                        error_shown_d = 1'b1;
                        stale_d       = 1'b0;
                    end else begin
                        decode_err_d = 1'b1;
                    end
                end
            end
        end
    end

    // Sync flops idle high so the released bus reads as a blank scan, not a bad anode pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1_q      <= 7'h7F;
            an_s1_q       <= 4'hF;
            seg_s2_q      <= 7'h7F;
            an_s2_q       <= 4'hF;
            seg_prev_q    <= 7'h7F;
            an_prev_q     <= 4'hF;
            stab_cnt_q    <= 8'd0;
            to_cnt_q      <= '0;
            mask_q        <= 4'b0000;
            slot_q        <= '0;
            value_q       <= 14'd0;
            value_valid_q <= 1'b0;
            error_shown_q <= 1'b0;
            decode_err_q  <= 1'b0;
            stale_q       <= 1'b1;
        end else begin
            seg_s1_q      <= seg_s1_d;
            an_s1_q       <= an_s1_d;
            seg_s2_q      <= seg_s2_d;
            an_s2_q       <= an_s2_d;
            seg_prev_q    <= seg_prev_d;
            an_prev_q     <= an_prev_d;
            stab_cnt_q    <= stab_cnt_d;
            to_cnt_q      <= to_cnt_d;
            mask_q        <= mask_d;
            slot_q        <= slot_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            error_shown_q <= error_shown_d;
            decode_err_q  <= decode_err_d;
            stale_q       <= stale_d;
        end
    end

    assign value_out   = value_q;
    assign value_valid = value_valid_q;
    assign error_shown = error_shown_q;
    assign decode_err  = decode_err_q;
    assign stale       = stale_q;

`ifdef SEG7_SCAN_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (decode_err_d && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt_q <= 8'd0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign decode_err_count = err_cnt_q;
`else
    assign decode_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized self-checking bench for seg7_scan_decoder against a frame-level reference model.
// The model tracks digit writes per scan slot and derives expected outputs arithmetically.
module tb_seg7_scan_decoder;

    localparam int STAB = 4;
    localparam int TO   = 3000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_decoder_if bus_if();

    logic [13:0] value_out;
    logic        value_valid, error_shown, decode_err, stale;
    logic [7:0]  decode_err_count;

    seg7_scan_decoder #(.STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus_if),
        .value_out        (value_out),
        .value_valid      (value_valid),
        .error_shown      (error_shown),
        .decode_err       (decode_err),
        .stale            (stale),
        .decode_err_count (decode_err_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int vv_seen  = 0;
    int de_seen  = 0;

    // Reference model state: bench-side codes 0..9 digits, 10 = E, 11 = r, 15 = blank.
    int         m_slot [4];
    logic [3:0] m_mask;
    int exp_value, exp_err, exp_stale, exp_vv, exp_de, exp_errcnt;

    always @(negedge clk) begin
        if (value_valid) vv_seen++;
        if (decode_err)  de_seen++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0000110;
            11: return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int k);
        logic [3:0] a;
        a = 4'b0001 << k;
        return ~a;
    endfunction

    task automatic note_err();
        exp_de++;
`ifdef SEG7_SCAN_ERRCNT_EN
        if (exp_errcnt < 255) exp_errcnt++;
`endif
    endtask

    // k < 0 or code < 0 marks an illegal anode or segment pattern.
    task automatic model_accept(input int k, input int code);
        bit numeric;
        if (k < 0 || code < 0) begin
            note_err();
            m_mask = 4'b0000;
            return;
        end
        m_slot[k] = code;
        m_mask[k] = 1'b1;
        if (m_mask == 4'b1111) begin
            m_mask  = 4'b0000;
            numeric = 1'b1;
            for (int i = 0; i < 4; i++) if (m_slot[i] > 9) numeric = 1'b0;
            if (numeric) begin
                exp_value = m_slot[3] * 1000 + m_slot[2] * 100 + m_slot[1] * 10 + m_slot[0];
                exp_vv++;
                exp_err   = 0;
                exp_stale = 0;
            end else if (m_slot[3] == 10 && m_slot[2] == 11 && m_slot[1] == 11 && m_slot[0] == 15) begin
                exp_err   = 1;
                exp_stale = 0;
            end else begin
                note_err();
            end
        end
    endtask

    task automatic model_timeout();
        m_mask    = 4'b0000;
        exp_stale = 1;
    endtask

    task automatic model_reset();
        m_mask     = 4'b0000;
        exp_value  = 0;
        exp_err    = 0;
        exp_stale  = 1;
        exp_errcnt = 0;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        bus_if.an_in  = an;
        bus_if.seg_in = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic scan_digit(input int k, input int code, input int hold, input int glen,
                              input logic [6:0] gpat);
        if (glen > 0) begin
            drive(an_of(k), seg_of(code), 12);
            drive(an_of(k), gpat, glen);
        end
        drive(an_of(k), seg_of(code), hold);
        model_accept(k, code);
        drive(4'hF, 7'($urandom), $urandom_range(1, 4));
    endtask

    task automatic scan_frame(input int c3, input int c2, input int c1, input int c0,
                              input int glitch_k, input int hold, input logic [6:0] gpat);
        int c [4];
        c[3] = c3; c[2] = c2; c[1] = c1; c[0] = c0;
        for (int k = 3; k >= 0; k--)
            scan_digit(k, c[k], hold, (k == glitch_k) ? $urandom_range(1, STAB - 1) : 0, gpat);
        drive(4'hF, 7'h7F, 10);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/value"},  value_out,        exp_value);
        chk({tag, "/err"},    error_shown,      exp_err);
        chk({tag, "/stale"},  stale,            exp_stale);
        chk({tag, "/vv"},     vv_seen,          exp_vv);
        chk({tag, "/de"},     de_seen,          exp_de);
        chk({tag, "/errcnt"}, decode_err_count, exp_errcnt);
    endtask

    initial begin
        int sel, d;
        exp_vv = 0;
        exp_de = 0;
        model_reset();
        bus_if.an_in  = 4'hF;
        bus_if.seg_in = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/vvalid", value_valid, 0);
        chk("rst/decerr", decode_err, 0);
        check_all("rst");
        reset_n = 1'b1;
        drive(4'hF, 7'h7F, 20);
        check_all("idle");

        scan_frame(1, 2, 3, 4, -1, 64, 7'h00);
        check_all("f1234");

        scan_frame(10, 11, 11, 15, -1, 40, 7'h00);
        check_all("ferr");

        scan_frame(9, 9, 9, 9, 2, 30, 7'b0000000);
        check_all("f9999_glitch");

        drive(4'b1001, seg_of(3), 10);
        model_accept(-1, 0);
        drive(4'hF, 7'h7F, 5);
        drive(an_of(2), 7'b1010101, 20);
        model_accept(-1, 0);
        drive(4'hF, 7'h7F, 10);
        check_all("illegal");

        scan_frame(5, 0, 5, 0, -1, 20, 7'h00);
        check_all("f5050");
        drive(4'hF, 7'h7F, TO - 200);
        check_all("pre_timeout");
        drive(4'hF, 7'h7F, 300);
        model_timeout();
        check_all("timeout");

        scan_digit(3, 7, 20, 0, 7'h00);
        scan_digit(2, 7, 20, 0, 7'h00);
        drive(4'hF, 7'h7F, TO + 50);
        model_timeout();
        scan_digit(1, 4, 20, 0, 7'h00);
        scan_digit(0, 2, 20, 0, 7'h00);
        drive(4'hF, 7'h7F, 10);
        check_all("partial_after_to");
        scan_frame(0, 0, 4, 2, -1, 24, 7'h00);
        check_all("f0042");

        scan_digit(3, 5, 20, 0, 7'h00);
        scan_digit(2, 6, 20, 0, 7'h00);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst/vvalid", value_valid, 0);
        chk("midrst/decerr", decode_err, 0);
        check_all("midrst");
        bus_if.an_in  = 4'hF;
        bus_if.seg_in = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(4'hF, 7'h7F, 10);
        scan_frame(0, 0, 0, 1, -1, 20, 7'h00);
        check_all("f0001");

        for (int f = 0; f < 12; f++) begin
            int c [4];
            sel = $urandom_range(0, 5);
            for (int k = 0; k < 4; k++) begin
                if (sel == 0) begin
                    d = $urandom_range(0, 12);
                    c[k] = (d == 12) ? 15 : d;
                end else begin
                    c[k] = $urandom_range(0, 9);
                end
            end
            if (sel == 1) begin
                c[3] = 10; c[2] = 11; c[1] = 11; c[0] = 15;
            end
            scan_frame(c[3], c[2], c[1], c[0],
                       ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : -1,
                       $urandom_range(12, 40), 7'($urandom));
            check_all($sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
